proc_sequencer: RTL
===================

PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-002 Resetn  input  1  asynchronous, active-low reset.
REQ-003 Start  input  1  level; in IDLE, begin continuous execution from StartAddr.
REQ-004 Step  input  1  level; in IDLE, execute exactly one instruction at current PC.
REQ-005 Stop  input  1  level; request halt at next instruction boundary.
REQ-006 StartAddr  input  7  program entry address, sampled only on Start.
REQ-007 LastAddr  input  7  address of final opcode word; halt after executing it.
REQ-008 MemAddr  output  7  program memory read address.
REQ-009 MemData  input  9  program memory read data, valid one cycle after MemAddr (synchronous read).
REQ-010 DIN  output  9  processor data-in bus.
REQ-011 Run  output  1  processor start strobe.
REQ-012 Done  input  1  processor completion flag (combinational, same cycle as final step).
REQ-013 Busy  output  1  high in any state except IDLE and ERROR.
REQ-014 Error  output  1  sticky fault flag, high in ERROR.
REQ-015 PC  output  7  current program counter.
REQ-016 InstrCount  output  16  instructions retired since last Start.

Function
REQ-017 States SHALL be IDLE, FETCH, ISSUE, IMM, WAIT, ERROR.
REQ-018 IDLE: Run=0, DIN=0; Start -> PC<=StartAddr, InstrCount<=0, continuous mode, FETCH; else Step -> single mode, FETCH; Start wins if both high.
REQ-019 FETCH (1 cycle): MemAddr=PC; -> ISSUE.
REQ-020 ISSUE (1 cycle): DIN=MemData, latch opcode=MemData[8:6]; opcode 000..011 -> Run=1; opcode 1xx -> Run=0, -> ERROR.
REQ-021 ISSUE with opcode 001 (mvi): MemAddr=PC+1 (mod 128), -> IMM; other legal opcodes -> WAIT.
REQ-022 IMM (1 cycle): DIN=MemData, Run=0; Done required this cycle, else -> ERROR; on Done PC<=PC+2 (mod 128).
REQ-023 WAIT: Run=0, DIN=0; on Done PC<=PC+1 (mod 128); watchdog: no Done within 3 WAIT cycles -> ERROR.
REQ-024 Retirement (Done in IMM/WAIT): InstrCount+=1 (wraps at 2^16); then -> IDLE if single mode, Stop high, or retired opcode address == LastAddr; else -> FETCH.
REQ-025 Retired mv SHALL take 3 cycles (FETCH, ISSUE, WAIT); mvi 3 cycles; add/sub 5 cycles.
REQ-026 LastAddr compare SHALL use the address of the opcode word, not the immediate word.
REQ-027 Stop SHALL never abort an in-flight instruction; Stop in IDLE is ignored.
REQ-028 Done outside IMM/WAIT SHALL be ignored.
REQ-029 ERROR: Run=0, DIN=0, PC frozen at faulting opcode address; exit only via Resetn.
REQ-030 MemAddr SHALL equal PC in all states except ISSUE-with-mvi.

Reset
REQ-031 Resetn low SHALL immediately force IDLE, PC=0, InstrCount=0, Run=0, DIN=0, Busy=0, Error=0, MemAddr=0, regardless of state.
REQ-032 Reset mid-instruction SHALL abandon it without retiring; processor is reset from the same Resetn.

Structure
REQ-033 Shared package proc_pkg SHALL hold opcode constants (mv=000, mvi=001, add=010, sub=011), state encoding, and widths 9/7/16.
REQ-034 No sub-module; PC, counter, watchdog, FSM inline. Instantiated alongside proc_1, sharing Clock/Resetn.

Verification
REQ-035 Program @0: mvi R0,#5; mvi R1,#3; add R0,R1; Start, StartAddr=0, LastAddr=4 -> R0=8, PC=5, InstrCount=3, Busy falls after 11 cycles.
REQ-036 Same program, Step pulses 3 times -> one retirement per pulse, PC 0->2->4->5, IDLE between.
REQ-037 Word 9'b100_000_000 at PC=3 -> Run never asserted for it, Error=1, PC=3, state holds until Resetn.
REQ-038 Stop raised during add WAIT -> add completes, IDLE, PC advanced by 1.
REQ-039 Resetn low in WAIT of sub -> next cycle IDLE, PC=0, InstrCount=0, destination register unchanged.
REQ-040 mvi at address 127 -> immediate fetched from 0, PC wraps to 1; stub holding Done low -> ERROR after 3 WAIT cycles.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants for the program sequencer and its processor: bus widths,
// opcode values and the sequencer FSM encoding.
package proc_pkg;
  localparam int DATA_W = 9;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 16;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Last watchdog count value tolerated while waiting for Done.
  localparam logic [1:0] WDOG_LAST = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_ERROR
  } state_e;
endpackage

// File: rtl/proc_sequencer.sv
// Program sequencer: fetches opcode words from a synchronous program memory,
// issues them to the processor and retires them on Done.
module proc_sequencer
  import proc_pkg::*;
(
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Step,
  input  logic              Stop,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W-1:0] LastAddr,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Error,
  output logic [ADDR_W-1:0] PC,
  output logic [CNT_W-1:0]  InstrCount
);

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         wdog_q;
  logic               single_q;

  logic [2:0]         opc;
  logic               issue_mvi;
  logic               halt;

  assign opc       = MemData[DATA_W-1 -: 3];
  assign issue_mvi = (state_q == S_ISSUE) && (opc == OP_MVI);
  // LastAddr matches the opcode word: pc_q still points at it when Done arrives.
  assign halt      = single_q || Stop || (pc_q == LastAddr);

  assign MemAddr    = issue_mvi ? pc_q + ADDR_W'(1) : pc_q;
  assign Run        = (state_q == S_ISSUE) && !opc[2];
  assign DIN        = (state_q == S_ISSUE || state_q == S_IMM) ? MemData : '0;
  assign Busy       = !(state_q == S_IDLE || state_q == S_ERROR);
  assign Error      = (state_q == S_ERROR);
  assign PC         = pc_q;
  assign InstrCount = cnt_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
      single_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            pc_q     <= StartAddr;
            cnt_q    <= '0;
            single_q <= 1'b0;
            state_q  <= S_FETCH;
          end else if (Step) begin
            single_q <= 1'b1;
            state_q  <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_ISSUE;
        S_ISSUE: begin
          wdog_q <= '0;
          if (opc[2])              state_q <= S_ERROR;
          else if (opc == OP_MVI)  state_q <= S_IMM;
          else                     state_q <= S_WAIT;
        end
        S_IMM: begin
          if (Done) begin
            pc_q    <= pc_q + ADDR_W'(2);
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= halt ? S_IDLE : S_FETCH;
          end else begin
            state_q <= S_ERROR;
          end
        end
        S_WAIT: begin
          if (Done) begin
            pc_q    <= pc_q + ADDR_W'(1);
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= halt ? S_IDLE : S_FETCH;
          end else if (wdog_q == WDOG_LAST) begin
            state_q <= S_ERROR;
          end else begin
            wdog_q <= wdog_q + 2'd1;
          end
        end
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
